// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display scheduler: service switch
// codes, owner codes and the digit segment pattern table.
package seg_pkg;

   // One-hot service switch codes, bit 3 = service 1 ... bit 0 = service 4.
   localparam logic [3:0] SERVICE1 = 4'b1000;
   localparam logic [3:0] SERVICE2 = 4'b0100;
   localparam logic [3:0] SERVICE3 = 4'b0010;
   localparam logic [3:0] SERVICE4 = 4'b0001;

   // Display owner; also the state of the owner FSM.
   typedef enum logic [2:0] {
      OWNER_IDLE = 3'd0,
      OWNER_S1   = 3'd1,
      OWNER_S2   = 3'd2,
      OWNER_S3   = 3'd3,
      OWNER_S4   = 3'd4
   } owner_e;

   // Segment patterns for digits 0-9, active-high, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_PATTERN [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Active-low cathode value with all seven segments dark.
   localparam logic [6:0] SEG_BLANK_N = 7'h7F;

   // Active-low cathode value with every segment including dp dark.
   localparam logic [7:0] SEG_OFF_N = 8'hFF;

   // Switch/finish bit that belongs to a given owner; zero for idle.
   function automatic logic [3:0] owner_onehot(input owner_e o);
      case (o)
         OWNER_S1: return SERVICE1;
         OWNER_S2: return SERVICE2;
         OWNER_S3: return SERVICE3;
         OWNER_S4: return SERVICE4;
         default:  return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD-to-cathode decoder. Output is active-low {dp,g,f,e,d,c,b,a}.
// Digit codes 10-15 show no segments; blank_i darkens the whole slot,
// decimal point included.
module seg_digit_decode
   import seg_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   // Pattern lookup, inversion to active-low and blanking.
   always_comb begin
      seg_o = SEG_OFF_N;
      if (!blank_i) begin
         seg_o[7] = ~dp_i;
         if (digit_i <= 4'd9) begin
            seg_o[6:0] = ~SEG_PATTERN[digit_i];
         end else begin
            seg_o[6:0] = SEG_BLANK_N;
         end
      end
   end

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates the shared 4-digit 7-segment display between the four services
// and the idle clock view. The owner only changes at a frame boundary (tick
// while the last digit is being scanned) and the owner's value is snapshotted
// at that same boundary, so a frame is never torn. seg and anode are
// registered together, one cycle after each scan tick.
//
// finish is a single-cycle pulse; it is honoured only from the current owner
// and latches a done bit that holds the service off the display until its
// switch is dropped.
module seg_display_scheduler
   import seg_pkg::*;
#(
   parameter int SCAN_DIV    = 100000,
   parameter int BLINK_TICKS = 250
) (
   input  logic        clk_osc,
   input  logic        reset,
   input  logic [3:0]  spdt_service,
   input  logic [3:0]  finish,
   input  logic [15:0] num1,
   input  logic [15:0] num2,
   input  logic [15:0] num3,
   input  logic [15:0] num4,
   input  logic [15:0] current_time,
   input  logic [3:0]  sel1,
   input  logic [3:0]  sel2,
   output logic [7:0]  seg,
   output logic [3:0]  anode,
   output logic [2:0]  owner
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [CW-1:0] TICK_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   // Scan timing
   logic [CW-1:0] tick_cnt_q;
   logic [1:0]    idx_q;
   logic          tick;
   logic          frame_end;

   // Ownership and snapshot
   logic [3:0]    done_q;
   logic [3:0]    done_d;
   owner_e        owner_q;
   owner_e        req_d;
   logic          owner_change;
   logic [15:0]   frame_val_q;
   logic [15:0]   frame_val_d;
   logic [3:0]    frame_sel_q;
   logic [3:0]    frame_sel_d;

   // Blink
   logic [BW-1:0] blink_cnt_q;
   logic          blink_on_q;

   // Output slot
   logic [3:0]    slot_digit;
   logic          slot_dp;
   logic          slot_blank;
   logic [7:0]    seg_d;
   logic [3:0]    anode_d;
   logic [7:0]    seg_q;
   logic [3:0]    anode_q;

   assign tick         = (tick_cnt_q == TICK_LAST);
   assign frame_end    = tick && (idx_q == 2'd3);
   assign owner_change = frame_end && (req_d != owner_q);

   // Scan divider and digit index; idx advances once per digit slot.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         tick_cnt_q <= '0;
         idx_q      <= 2'd0;
      end else begin
         if (tick) begin
            tick_cnt_q <= '0;
            idx_q      <= idx_q + 2'd1;
         end else begin
            tick_cnt_q <= tick_cnt_q + CW'(1);
         end
      end
   end

   // Done bits: set by the owner's own finish, cleared whenever the switch is
   // down. Kept combinational so a finish on the boundary cycle is seen by
   // the request below in that same cycle.
   assign done_d = (done_q | (finish & owner_onehot(owner_q))) & spdt_service;

   // Request: exactly one switch up and not yet finished, otherwise idle.
   always_comb begin
      req_d = OWNER_IDLE;
      case (spdt_service)
         SERVICE1: if (!done_d[3]) req_d = OWNER_S1;
         SERVICE2: if (!done_d[2]) req_d = OWNER_S2;
         SERVICE3: if (!done_d[1]) req_d = OWNER_S3;
         SERVICE4: if (!done_d[0]) req_d = OWNER_S4;
         default:  req_d = OWNER_IDLE;
      endcase
   end

   // Source selection for the snapshot taken on behalf of the next owner.
   always_comb begin
      frame_val_d = current_time;
      frame_sel_d = 4'b0000;
      case (req_d)
         OWNER_S1: begin
            frame_val_d = num1;
            frame_sel_d = sel1;
         end
         OWNER_S2: begin
            frame_val_d = num2;
            frame_sel_d = sel2;
         end
         OWNER_S3: frame_val_d = num3;
         OWNER_S4: frame_val_d = num4;
         default:  frame_val_d = current_time;
      endcase
   end

   // Done register.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         done_q <= 4'b0000;
      end else begin
         done_q <= done_d;
      end
   end

   // Owner FSM and frame snapshot; both move only at a frame boundary.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         owner_q     <= OWNER_IDLE;
         frame_val_q <= 16'h0000;
         frame_sel_q <= 4'b0000;
      end else if (frame_end) begin
         owner_q     <= req_d;
         frame_val_q <= frame_val_d;
         frame_sel_q <= frame_sel_d;
      end
   end

   // Blink phase: toggles every BLINK_TICKS slots, restarts lit on a new owner.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (owner_change) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
         end
      end
   end

   // Digit, decimal point, blink blanking and anode for the slot being scanned.
   // frame_sel bit 3 is the leftmost digit, so the slot's bit is 3-idx (~idx).
   always_comb begin
      case (idx_q)
         2'd0:    slot_digit = frame_val_q[15:12];
         2'd1:    slot_digit = frame_val_q[11:8];
         2'd2:    slot_digit = frame_val_q[7:4];
         default: slot_digit = frame_val_q[3:0];
      endcase
      slot_dp    = (idx_q == 2'd1);
      slot_blank = ~blink_on_q & frame_sel_q[~idx_q];
      anode_d    = ~(4'b1000 >> idx_q);
   end

   seg_digit_decode u_decode (
      .digit_i (slot_digit),
      .dp_i    (slot_dp),
      .blank_i (slot_blank),
      .seg_o   (seg_d)
   );

   // Output registers; seg and anode always load on the same tick.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         seg_q   <= SEG_OFF_N;
         anode_q <= 4'b1111;
      end else if (tick) begin
         seg_q   <= seg_d;
         anode_q <= anode_d;
      end
   end

   assign seg   = seg_q;
   assign anode = anode_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with SCAN_DIV=4, BLINK_TICKS=2.
// Expected cathode values are hand-computed from the digit pattern table
// (active-low, dp lit only on the second digit) and queued in exp_q.
module tb_seg_display_scheduler;

   logic        clk_osc = 1'b0;
   logic        reset;
   logic [3:0]  spdt_service;
   logic [3:0]  finish;
   logic [15:0] num1, num2, num3, num4;
   logic [15:0] current_time;
   logic [3:0]  sel1, sel2;
   logic [7:0]  seg;
   logic [3:0]  anode;
   logic [2:0]  owner;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   seg_display_scheduler #(
      .SCAN_DIV    (4),
      .BLINK_TICKS (2)
   ) dut (
      .clk_osc      (clk_osc),
      .reset        (reset),
      .spdt_service (spdt_service),
      .finish       (finish),
      .num1         (num1),
      .num2         (num2),
      .num3         (num3),
      .num4         (num4),
      .current_time (current_time),
      .sel1         (sel1),
      .sel2         (sel2),
      .seg          (seg),
      .anode        (anode),
      .owner        (owner)
   );

   // Clock
   always #5 clk_osc = ~clk_osc;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) at falling edges until the given anode pattern shows.
   task automatic wait_anode(input logic [3:0] a, input string tag);
      int n = 0;
      while (anode !== a && n < 40) begin
         @(negedge clk_osc);
         n++;
      end
      check({tag, "_anode"}, 16'(anode), 16'(a));
   endtask

   task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
      exp_q.push_back(s0);
      exp_q.push_back(s1);
      exp_q.push_back(s2);
      exp_q.push_back(s3);
   endtask

   // Reads one full frame, left to right, against the queued expectations.
   task automatic read_frame(input string tag);
      logic [3:0] an [4];
      logic [7:0] e;
      an[0] = 4'b0111;
      an[1] = 4'b1011;
      an[2] = 4'b1101;
      an[3] = 4'b1110;
      for (int k = 0; k < 4; k++) begin
         wait_anode(an[k], tag);
         e = exp_q.pop_front();
         check($sformatf("%s_seg%0d", tag, k), 16'(seg), 16'(e));
      end
   endtask

   // Returns just after the next frame boundary.
   task automatic sync_frame(input string tag);
      wait_anode(4'b1101, tag);
      wait_anode(4'b1110, tag);
   endtask

   task automatic pulse_finish(input logic [3:0] f);
      finish = f;
      @(negedge clk_osc);
      finish = 4'b0000;
   endtask

   initial begin
      int n;
      reset        = 1'b1;
      spdt_service = 4'b0000;
      finish       = 4'b0000;
      num1         = 16'h0000;
      num2         = 16'h0000;
      num3         = 16'h0000;
      num4         = 16'h0000;
      current_time = 16'h1234;
      sel1         = 4'b0000;
      sel2         = 4'b0000;

      // 1. Reset and idle scan
      repeat (3) @(negedge clk_osc);
      check("rst_seg", 16'(seg), 16'h00FF);
      check("rst_anode", 16'(anode), 16'h000F);
      check("rst_owner", 16'(owner), 16'd0);
      reset = 1'b0;
      n = 0;
      while (anode === 4'b1111 && n < 20) begin
         @(negedge clk_osc);
         n++;
      end
      check("first_anode_cycles", 16'(n), 16'd4);
      push_frame(8'hC0, 8'h40, 8'hC0, 8'hC0);
      read_frame("reset_frame");
      push_frame(8'hF9, 8'h24, 8'hB0, 8'h99);
      read_frame("idle_1234");

      // 2. Owner change only at the frame boundary
      wait_anode(4'b1011, "t2_mid");
      spdt_service = 4'b1000;
      num1         = 16'h0559;
      check("t2_owner_mid", 16'(owner), 16'd0);
      wait_anode(4'b1101, "t2_slot2");
      check("t2_owner_before_fb", 16'(owner), 16'd0);
      wait_anode(4'b1110, "t2_slot3");
      check("t2_owner_after_fb", 16'(owner), 16'd1);
      push_frame(8'hC0, 8'h12, 8'h92, 8'h90);
      read_frame("s1_0559");

      // 3. Blink on the edit digit
      sel1 = 4'b0010;
      sync_frame("t3_sync");
      push_frame(8'hC0, 8'h12, 8'hFF, 8'h90);
      read_frame("blink_d2_a");
      push_frame(8'hC0, 8'h12, 8'hFF, 8'h90);
      read_frame("blink_d2_b");
      sel1 = 4'b0001;
      sync_frame("t3_sync2");
      push_frame(8'hC0, 8'h12, 8'h92, 8'hFF);
      read_frame("blink_d3");
      sel1 = 4'b1000;
      sync_frame("t3_sync3");
      push_frame(8'hC0, 8'h12, 8'h92, 8'h90);
      read_frame("blink_d0_lit");
      sel1 = 4'b0000;
      sync_frame("t3_sync4");

      // 4. Finish mid-frame, done latch, re-raise, finish on the boundary
      wait_anode(4'b1011, "t4_mid");
      pulse_finish(4'b1000);
      check("t4_owner_mid_after_finish", 16'(owner), 16'd1);
      sync_frame("t4_sync");
      check("t4_owner_retired", 16'(owner), 16'd0);
      push_frame(8'hF9, 8'h24, 8'hB0, 8'h99);
      read_frame("t4_idle");
      sync_frame("t4_sync_hold");
      check("t4_done_hold", 16'(owner), 16'd0);
      spdt_service = 4'b0000;
      @(negedge clk_osc);
      spdt_service = 4'b1000;
      sync_frame("t4_sync_reraise");
      check("t4_owner_reraise", 16'(owner), 16'd1);
      wait_anode(4'b1101, "t4_fb");
      repeat (3) @(negedge clk_osc);
      check("t4_owner_pre_fb", 16'(owner), 16'd1);
      pulse_finish(4'b1000);
      check("t4_owner_fb_finish", 16'(owner), 16'd0);
      check("t4_anode_fb_finish", 16'(anode), 16'h000E);

      // 5. Invalid switch pattern, foreign finish, blank digit
      spdt_service = 4'b0000;
      @(negedge clk_osc);
      spdt_service = 4'b1000;
      sync_frame("t5_sync_a");
      check("t5_owner_s1", 16'(owner), 16'd1);
      spdt_service = 4'b1100;
      sync_frame("t5_sync_b");
      check("t5_owner_multihot", 16'(owner), 16'd0);
      spdt_service = 4'b1000;
      sync_frame("t5_sync_c");
      check("t5_owner_s1_again", 16'(owner), 16'd1);
      wait_anode(4'b1011, "t5_mid");
      pulse_finish(4'b0100);
      sync_frame("t5_sync_d");
      check("t5_foreign_finish", 16'(owner), 16'd1);
      num1 = 16'h00A0;
      sync_frame("t5_sync_e");
      push_frame(8'hC0, 8'h40, 8'hFF, 8'hC0);
      read_frame("blank_digit");

      // 6. Reset mid-frame while service 2 owns the display
      spdt_service = 4'b0100;
      num2         = 16'h4321;
      sync_frame("t6_sync");
      check("t6_owner_s2", 16'(owner), 16'd2);
      push_frame(8'h99, 8'h30, 8'hA4, 8'hF9);
      read_frame("s2_4321");
      wait_anode(4'b1011, "t6_mid");
      @(negedge clk_osc);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_seg", 16'(seg), 16'h00FF);
      check("t6_rst_anode", 16'(anode), 16'h000F);
      check("t6_rst_owner", 16'(owner), 16'd0);
      repeat (2) @(negedge clk_osc);
      reset = 1'b0;
      n = 0;
      while (anode === 4'b1111 && n < 20) begin
         @(negedge clk_osc);
         n++;
      end
      check("t6_first_anode_cycles", 16'(n), 16'd4);
      check("t6_owner_first_frame", 16'(owner), 16'd0);
      push_frame(8'hC0, 8'h40, 8'hC0, 8'hC0);
      read_frame("t6_reset_frame");
      check("t6_owner_after_fb", 16'(owner), 16'd2);
      push_frame(8'h99, 8'h30, 8'hA4, 8'hF9);
      read_frame("t6_s2_4321");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
